// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the LVDS front-end reset sequencer.
// Holds the FSM state encoding and counter sizing helper.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDC_RST,
    S_WAIT_RDY,
    S_SERDES_RST,
    S_DP_RST,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic int max_count(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Status inputs and reset outputs of the front-end reset sequencer.
// master = sequencer side, slave = consumer/PHY side.
interface reset_sequencer_if;

  logic mmcm_locked;
  logic idelayctrl_rdy;
  logic idelayctrl_rst;
  logic iserdes_rst;
  logic datapath_rst_n;
  logic seq_done;
  logic seq_error;

  modport master (
    input  mmcm_locked,
    input  idelayctrl_rdy,
    output idelayctrl_rst,
    output iserdes_rst,
    output datapath_rst_n,
    output seq_done,
    output seq_error
  );

  modport slave (
    output mmcm_locked,
    output idelayctrl_rdy,
    input  idelayctrl_rst,
    input  iserdes_rst,
    input  datapath_rst_n,
    input  seq_done,
    input  seq_error
  );

endinterface

// File: rtl/bit_sync.sv
// Multi-stage flip-flop synchronizer with asynchronous clear.
// Output follows input after STAGES rising edges.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Orders MMCM lock, IDELAYCTRL, ISERDES and datapath reset release.
// Define RESET_SEQ_TIMEOUT_EN for the ready watchdog with retries.
import reset_seq_pkg::*;

module reset_sequencer #(
  parameter int IDC_RST_CYCLES    = 64,
  parameter int SERDES_RST_CYCLES = 16,
  parameter int DP_RST_CYCLES     = 16,
  parameter int SYNC_STAGES       = 2,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int MAX_RETRIES       = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  reset_sequencer_if.master  bus
);

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int MAXC = max_count(
    IDC_RST_CYCLES, SERDES_RST_CYCLES,
    DP_RST_CYCLES, TIMEOUT_CYCLES);
`else
  localparam int MAXC = max_count(
    IDC_RST_CYCLES, SERDES_RST_CYCLES,
    DP_RST_CYCLES, 1);
`endif
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] IDC_LAST =
    CW'(IDC_RST_CYCLES - 1);
  localparam logic [CW-1:0] SER_LAST =
    CW'(SERDES_RST_CYCLES - 1);
  localparam logic [CW-1:0] DP_LAST =
    CW'(DP_RST_CYCLES - 1);

  if (IDC_RST_CYCLES < 1 || SERDES_RST_CYCLES < 1 ||
      DP_RST_CYCLES < 1 || SYNC_STAGES < 2 ||
      TIMEOUT_CYCLES < 1 || MAX_RETRIES < 0)
  begin : g_bad_param
    $error("reset_sequencer: illegal parameter value");
  end

  logic lock_s;
  logic rdy_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.mmcm_locked),
    .q     (lock_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.idelayctrl_rdy),
    .q     (rdy_s)
  );

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          counted;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam int RW =
    (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  logic [RW-1:0] retry;
  logic          err_q;
`endif

  always_comb begin
    counted = (state == S_IDC_RST)    ||
              (state == S_SERDES_RST) ||
              (state == S_DP_RST);
`ifdef RESET_SEQ_TIMEOUT_EN
    if (state == S_WAIT_RDY) counted = 1'b1;
`endif
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_WAIT_LOCK: if (lock_s) nxt = S_IDC_RST;
      S_IDC_RST:   if (cnt == IDC_LAST) nxt = S_WAIT_RDY;
      S_WAIT_RDY: begin
        if (rdy_s) nxt = S_SERDES_RST;
`ifdef RESET_SEQ_TIMEOUT_EN
        else if (cnt == TO_LAST)
          nxt = (retry == RETRY_MAX) ? S_ERROR : S_IDC_RST;
`endif
      end
      S_SERDES_RST: begin
        if (!rdy_s)                nxt = S_IDC_RST;
        else if (cnt == SER_LAST)  nxt = S_DP_RST;
      end
      S_DP_RST: begin
        if (!rdy_s)               nxt = S_IDC_RST;
        else if (cnt == DP_LAST)  nxt = S_DONE;
      end
      S_DONE:  if (!rdy_s) nxt = S_IDC_RST;
      default: nxt = state;
    endcase
    // Lock loss overrides everything, including ready loss.
    if (!lock_s && state != S_WAIT_LOCK &&
        state != S_ERROR)
      nxt = S_WAIT_LOCK;
  end

  logic idc_q;
  logic ser_q;
  logic dp_n_q;
  logic done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_WAIT_LOCK;
      cnt    <= '0;
      idc_q  <= 1'b1;
      ser_q  <= 1'b1;
      dp_n_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (counted) cnt <= cnt + CW'(1);
      idc_q  <= (nxt == S_WAIT_LOCK) ||
                (nxt == S_IDC_RST)   ||
                (nxt == S_ERROR);
      ser_q  <= (nxt != S_DP_RST) && (nxt != S_DONE);
      dp_n_q <= (nxt == S_DONE);
      done_q <= (nxt == S_DONE);
    end
  end

`ifdef RESET_SEQ_TIMEOUT_EN
  // Retries survive lock loss; only success or reset clears them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retry <= '0;
      err_q <= 1'b0;
    end else begin
      if (nxt == S_DONE)
        retry <= '0;
      else if (state == S_WAIT_RDY && nxt == S_IDC_RST)
        retry <= retry + RW'(1);
      err_q <= (nxt == S_ERROR);
    end
  end

  assign bus.seq_error = err_q;
`else
  assign bus.seq_error = 1'b0;
`endif

  assign bus.idelayctrl_rst = idc_q;
  assign bus.iserdes_rst    = ser_q;
  assign bus.datapath_rst_n = dp_n_q;
  assign bus.seq_done       = done_q;

endmodule
